// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
//   Owns the single GRF write port. The in-order W stage always wins the port
//   and is never stalled. Results from the long-latency unit (LU) are queued
//   in a small in-order FIFO and drain into cycles the W stage leaves idle.
//   A W write to register X makes any queued LU result for X stale. The
//   arbiter marks such entries dead, and they are later discarded without
//   writing the GRF. Live queued destinations are reported to the D-stage
//   hazard unit.
//
// Parameters
//   DEPTH  LU result FIFO entries (power of 2, >= 2)
//   AW     register address width
//   DW     write data width
//
// Ports
//   clk, reset                  clock, synchronous active-low reset
//   w_we_i, w_a3_i, w_wd_i      W-stage write request
//   lu_valid_i, lu_a3_i,
//   lu_wd_i, lu_ready_o         LU result handshake (accepted when valid && ready)
//   d_a1_i, d_a2_i              D-stage source addresses
//   pend_hit_a1_o/_a2_o         a live queued write targets that source
//   grf_we_o, grf_a3_o,
//   grf_wd_o                    GRF write port
//   fifo_cnt_o                  occupied FIFO entries, live and dead
module grf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_we_i,
  input  logic [AW-1:0]            w_a3_i,
  input  logic [DW-1:0]            w_wd_i,
  input  logic                     lu_valid_i,
  input  logic [AW-1:0]            lu_a3_i,
  input  logic [DW-1:0]            lu_wd_i,
  output logic                     lu_ready_o,
  input  logic [AW-1:0]            d_a1_i,
  input  logic [AW-1:0]            d_a2_i,
  output logic                     grf_we_o,
  output logic [AW-1:0]            grf_a3_o,
  output logic [DW-1:0]            grf_wd_o,
  output logic                     pend_hit_a1_o,
  output logic                     pend_hit_a2_o,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO state: live bits, pointers and count are control and are reset.
  // The payload arrays are only ever read behind a live bit, so they are not.
  logic [DEPTH-1:0] live_q;
  logic [AW-1:0]    a3_q [DEPTH];
  logic [DW-1:0]    wd_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    cnt_q;

  logic             w_wins;
  logic             fifo_nonempty;
  logic             fifo_full;
  logic             head_live;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] live_d;
  logic             hit1_raw;
  logic             hit2_raw;

  // W writes to $0 are architecturally dropped and never claim the port.
  assign w_wins        = w_we_i && (w_a3_i != '0);
  assign fifo_nonempty = (cnt_q != '0);
  assign fifo_full     = (cnt_q == CW'(DEPTH));
  assign head_live     = fifo_nonempty && live_q[rd_ptr_q];

  // Ready is a function of the registered count only. A pop while full does
  // not reopen the FIFO until the following cycle.
  assign lu_ready_o = reset && !fifo_full;

  // LU results to $0 are accepted and thrown away. They are never queued.
  assign push = lu_valid_i && lu_ready_o && (lu_a3_i != '0);

  // A dead head leaves in any cycle. A live head leaves only when it
  // actually gets the write port.
  assign pop = reset && fifo_nonempty && (!live_q[rd_ptr_q] || !w_wins);

  assign fifo_cnt_o = cnt_q;

  // Write port grant
  always_comb begin
    grf_we_o = 1'b0;
    grf_a3_o = '0;
    grf_wd_o = '0;
    if (reset) begin
      if (w_wins) begin
        grf_we_o = 1'b1;
        grf_a3_o = w_a3_i;
        grf_wd_o = w_wd_i;
      end else if (head_live) begin
        grf_we_o = 1'b1;
        grf_a3_o = a3_q[rd_ptr_q];
        grf_wd_o = wd_q[rd_ptr_q];
      end
    end
  end

  // Pending-write hits, taken from registered FIFO state only
  always_comb begin
    hit1_raw = 1'b0;
    hit2_raw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (a3_q[i] == d_a1_i)) hit1_raw = 1'b1;
      if (live_q[i] && (a3_q[i] == d_a2_i)) hit2_raw = 1'b1;
    end
    pend_hit_a1_o = reset && (d_a1_i != '0) && hit1_raw;
    pend_hit_a2_o = reset && (d_a2_i != '0) && hit2_raw;
  end

  // Next live bits.
  // The W instruction is younger than every queued LU result, so a W write
  // to X makes every queued X stale. The entry pushed this same cycle is
  // applied last, so it survives. Popped slots are cleared so that live
  // bits only ever mark occupied slots.
  always_comb begin
    live_d = live_q;
    if (w_wins) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (a3_q[i] == w_a3_i) live_d[i] = 1'b0;
      end
    end
    if (pop)  live_d[rd_ptr_q] = 1'b0;
    if (push) live_d[wr_ptr_q] = 1'b1;
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      live_q   <= '0;
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      live_q <= live_d;
    end
  end

  // FIFO payload registers
  always_ff @(posedge clk) begin
    if (push) begin
      a3_q[wr_ptr_q] <= lu_a3_i;
      wd_q[wr_ptr_q] <= lu_wd_i;
    end
  end

endmodule
